addsub16_seq: RTL and testbench
===============================

ADDSUB16_SEQ -- requirements
Module: addsub16_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operation; data width W = 4*NIBBLES.
REQ-002 Port clk  input  1  single clock for all state; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port start  input  1  request; sampled only when busy=0.
REQ-005 Port sub  input  1  0 = A+B, 1 = A-B; latched with start.
REQ-006 Port sat  input  1  1 = saturate signed overflow; latched with start.
REQ-007 Port a, b  input  W each  operands; latched with start.
REQ-008 Port sum  output  W  result.
REQ-009 Port cout  output  1  carry out of the MSB slice.
REQ-010 Port ov  output  1  signed overflow of the unsaturated result.
REQ-011 Port zero  output  1  final sum == 0.
REQ-012 Port busy  output  1  high in RUN and DONE.
REQ-013 Port done  output  1  one-cycle completion pulse.

Function
REQ-014 The datapath SHALL be one 4-bit carry-lookahead slice with inputs nibble A, nibble B', carry-in; it is reused for every nibble, LSB first.
REQ-015 States: IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE, start=1 at an edge: latch a to opA, latch (sub ? ~b : b) to opB, carry register <= sub, idx <= 0, latch sat; go RUN.
REQ-017 IDLE, start=0: hold state; outputs unchanged.
REQ-018 RUN, each edge: slice output written to sum[4*idx+3:4*idx], carry register <= slice Cout, idx <= idx+1.
REQ-019 RUN, edge with idx = NIBBLES-1: cout <= slice Cout, ov <= slice Cout XOR carry into slice MSB, zero and saturation applied, go DONE.
REQ-020 Saturation: when latched sat=1 and ov=1, sum SHALL be written as opA[W-1] ? 1 followed by W-1 zeros : 0 followed by W-1 ones; ov still reports 1; zero is computed on the written value.
REQ-021 DONE: done=1 for exactly this cycle; the next edge returns to IDLE unconditionally.
REQ-022 Latency: exactly NIBBLES+1 rising edges from the edge sampling start to the edge leaving DONE; done is high between edges NIBBLES and NIBBLES+1.
REQ-023 start while busy=1, including in the DONE cycle, SHALL be ignored, with no queuing.
REQ-024 Changes on a, b, sub or sat after the latching edge SHALL NOT affect the result.
REQ-025 sum, cout, ov and zero SHALL be registered; they are valid from the done cycle and held until the next accepted start.
REQ-026 sum is undefined during RUN, because nibbles are partially updated.
REQ-027 cout for subtraction SHALL equal NOT borrow: 1 when a >= b unsigned.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, idx=0, carry=0, sum=0, cout=0, ov=0, zero=0, busy=0, done=0, regardless of clock.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after rst_n deasserts is accepted normally.

Verification
REQ-030 a=0x1234, b=0x0FFF, sub=0, sat=0 -> after 4 RUN edges: done=1, sum=0x2233, cout=0, ov=0, zero=0.
REQ-031 a=0x7FFF, b=0x0001, sub=0 -> sat=0: sum=0x8000, ov=1, cout=0; sat=1: sum=0x7FFF, ov=1.
REQ-032 a=0x0005, b=0x0005, sub=1 -> sum=0x0000, zero=1, cout=1, ov=0; a=0x8000, b=0x0001, sub=1, sat=1 -> sum=0x8000, ov=1.
REQ-033 start held high continuously with operands changing each cycle -> one done every 6 cycles; each result matches operands present at its accepting edge; busy never drops during RUN/DONE.
REQ-034 rst_n pulsed low at RUN idx=2 -> all outputs 0 asynchronously, no done pulse; following start with a=0x0001, b=0x0001 -> sum=0x0002 on time.
REQ-035 Random add/sub/sat regression (>=10k ops) against a reference model: sum, cout, ov, zero and done timing exact.

Source files
------------

// File: rtl/addsub16_seq.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice is reused LSB first,
// with optional signed saturation applied when the last nibble is written.
module addsub16_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 sat,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ov,
  output logic                 zero,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]      sum_q, sum_d, sum_new;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d, sat_q, sat_d;
  logic              cout_q, cout_d, ov_q, ov_d, zero_q, zero_d;
  logic              ov_new;
  logic [3:0]        nib_a, nib_b, g, p, slice_s;
  logic [4:0]        c;

  // Operand nibble selected by the current slice index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_a = opa_q[4*i +: 4];
        nib_b = opb_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    slice_s = p ^ c[3:0];
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    zero_d  = zero_q;
    sum_new = sum_q;
    ov_new  = c[4] ^ c[3];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
          sat_d   = sat;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IdxW'(i)) sum_new[4*i +: 4] = slice_s;
        end
        carry_d = c[4];
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NIBBLES - 1)) begin
          cout_d = c[4];
          ov_d   = ov_new;
          if (sat_q && ov_new) begin
            sum_new = opa_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
          zero_d  = (sum_new == '0);
          idx_d   = '0;
          state_d = StDone;
        end
        sum_d = sum_new;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ov   = ov_q;
  assign zero = zero_q;
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_addsub16_seq.sv
// Randomised and directed bench for addsub16_seq against an integer-arithmetic reference model.
module tb_addsub16_seq;

  localparam int NIB = 4;

  logic        clk, rst_n, start, sub, sat;
  logic [15:0] a, b, sum;
  logic        cout, ov, zero, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  addsub16_seq #(.NIBBLES(NIB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .sat  (sat),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout),
    .ov   (ov),
    .zero (zero),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Signed/unsigned arithmetic on whole words; no slicing or carry chains.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic msub, input logic msat,
                                output logic [15:0] s, output logic c,
                                output logic v, output logic z);
    int sa, sb, r;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = msub ? (sa - sb) : (sa + sb);
    v  = (r > 32767) || (r < -32768);
    c  = msub ? (ma >= mb) : ((int'(ma) + int'(mb)) > 65535);
    s  = r[15:0];
    if (msat && v) s = (r > 0) ? 16'h7FFF : 16'h8000;
    z  = (s == 16'h0000);
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                        input logic tsat);
    logic [15:0] es;
    logic        ec, ev, ez;
    model(ta, tb, tsub, tsat, es, ec, ev, ez);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; sat = tsat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    check("busy_accept", busy, 1);
    for (int k = 1; k <= NIB + 1; k++) begin
      @(posedge clk); #1;
      check("done_timing", done, (k == NIB));
      if (k == NIB) begin
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ov", ov, ev);
        check("zero", zero, ez);
      end
      if (k == NIB + 1) begin
        check("busy_idle", busy, 0);
        check("sum_held", sum, es);
      end
    end
  endtask

  logic [15:0] ha [18];
  logic [15:0] hb [18];
  logic        hs [18];
  logic        ht [18];

  initial begin
    logic [15:0] es;
    logic        ec, ev, ez;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; sat = 1'b0; a = '0; b = '0;
    #23;
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ov, zero, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("dir_add", {sum, cout, ov, zero}, {16'h2233, 3'b000});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("dir_ovf", {sum, cout, ov}, {16'h8000, 2'b01});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    check("dir_sat_pos", {sum, ov}, {16'h7FFF, 1'b1});
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0);
    check("dir_sub_zero", {sum, zero, cout, ov}, {16'h0000, 3'b110});
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    check("dir_sat_neg", {sum, ov}, {16'h8000, 1'b1});

    // start held high with operands changing every cycle: one result every 6 edges.
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      ha[cyc] = 16'($urandom); hb[cyc] = 16'($urandom);
      hs[cyc] = 1'($urandom);  ht[cyc] = 1'($urandom);
      a = ha[cyc]; b = hb[cyc]; sub = hs[cyc]; sat = ht[cyc]; start = 1'b1;
      @(posedge clk); #1;
      check("stream_done", done, (cyc % 6 == 4));
      check("stream_busy", busy, (cyc % 6 != 5));
      if (cyc % 6 == 4) begin
        model(ha[cyc-4], hb[cyc-4], hs[cyc-4], ht[cyc-4], es, ec, ev, ez);
        check("stream_res", {sum, cout, ov, zero}, {es, ec, ev, ez});
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN (idx = 2).
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum", sum, 0);
    check("arst_flags", {cout, ov, zero, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("arst_no_done", done, 0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    check("after_rst", sum, 16'h0002);

    for (int n = 0; n < 10000; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
